vga_timing_gen: RTL

- Parametrised VGA timing generator that replaces the fixed 800x600 timing unit at the head of the pixel pipeline (timing -> draw_background -> draw_rect -> output register).
- Produces hcount/vcount, sync and blanking for any resolution set by parameters, with selectable sync polarity.
- Adds a clock-enable stall, line/frame start strobes and a frame counter.
- Has a configurable output delay line so downstream draw stages can be retimed without extra glue.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_delay_line.sv | 36 +++
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and bus types for the pixel pipeline
// (timing -> draw_background -> draw_rect -> output register).
package vga_pkg;

  // SVGA 800x600@60 (40 MHz pixel clock)
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  localparam int VGA_CW  = 11;
  localparam int VGA_FCW = 16;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Per-pixel timing bundle handed between draw stages.
  typedef struct packed {
    logic [VGA_CW-1:0] hcount;
    logic [VGA_CW-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
  } vga_bus_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing output bundle of vga_timing_gen: the generator drives it as master,
// draw stages consume it as slave.
interface vga_timing_gen_if #(
  parameter int CW  = 11,
  parameter int FCW = 16
);
  logic [CW-1:0]  hcount;
  logic [CW-1:0]  vcount;
  logic           hsync;
  logic           vsync;
  logic           hblnk;
  logic           vblnk;
  logic           line_start;
  logic           frame_start;
  logic [FCW-1:0] frame_cnt;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk,
          line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register chain with a synchronous reset value; DEPTH=0 is a wire.
// Used for output retiming of timing and, downstream, of rgb/sync.
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = ^{i_clk, i_rst, i_rst_val};
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shifts every cycle so the pipe always drains, independent of any stall.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= i_rst_val;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with clock-enable stall, line/frame strobes,
// completed-frame counter and an optional output delay line.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = VGA_CW,
  parameter int FCW      = VGA_FCW,
  parameter int OUT_DLY  = 0
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                ce,
  vga_timing_gen_if.master    o_vga
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] C_H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] C_V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] C_H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] C_V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] C_HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] C_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] C_VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] C_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam int W = 2*CW + 6 + FCW;

  // r_hc/r_vc/r_frames hold the position about to be presented; the r_* output
  // registers below capture it and its decodes together, keeping all aligned.
  logic [CW-1:0]  r_hc;
  logic [CW-1:0]  r_vc;
  logic [FCW-1:0] r_frames;

  logic [CW-1:0]  r_hcount;
  logic [CW-1:0]  r_vcount;
  logic           r_hsync;
  logic           r_vsync;
  logic           r_hblnk;
  logic           r_vblnk;
  logic           r_line_start;
  logic           r_frame_start;
  logic [FCW-1:0] r_fcnt;

  logic           w_h_last;
  logic           w_v_last;
  logic           w_hs_act;
  logic           w_vs_act;

  assign w_h_last = (r_hc == C_H_LAST);
  assign w_v_last = (r_vc == C_V_LAST);
  assign w_hs_act = (r_hc >= C_HS_BEG) && (r_hc < C_HS_END);
  assign w_vs_act = (r_vc >= C_VS_BEG) && (r_vc < C_VS_END);

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_hc     <= '0;
      r_vc     <= '0;
      r_frames <= '0;
    end else if (ce) begin
      if (w_h_last) begin
        r_hc <= '0;
        if (w_v_last) begin
          r_vc     <= '0;
          r_frames <= r_frames + 1'b1;
        end else begin
          r_vc <= r_vc + 1'b1;
        end
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end
  end

  // Strobes default low every cycle so a stall can never repeat them.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_fcnt        <= '0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (ce) begin
        r_hcount      <= r_hc;
        r_vcount      <= r_vc;
        r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
        r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
        r_hblnk       <= (r_hc >= C_H_ACT);
        r_vblnk       <= (r_vc >= C_V_ACT);
        r_line_start  <= (r_hc == '0);
        r_frame_start <= (r_hc == '0) && (r_vc == '0);
        r_fcnt        <= r_frames;
      end
    end
  end

  logic [W-1:0] w_pre;
  logic [W-1:0] w_post;
  logic [W-1:0] w_rst_val;

  assign w_pre = {r_hcount, r_vcount, r_hsync, r_vsync, r_hblnk, r_vblnk,
                  r_line_start, r_frame_start, r_fcnt};
  assign w_rst_val = {{(2*CW){1'b0}}, ~HS_POL, ~VS_POL, 4'b0000, {FCW{1'b0}}};

  vga_delay_line #(
    .DEPTH (OUT_DLY),
    .WIDTH (W)
  ) u_out_dly (
    .i_clk     (pclk),
    .i_rst     (rst),
    .i_rst_val (w_rst_val),
    .i_d       (w_pre),
    .o_q       (w_post)
  );

  assign {o_vga.hcount, o_vga.vcount, o_vga.hsync, o_vga.vsync, o_vga.hblnk,
          o_vga.vblnk, o_vga.line_start, o_vga.frame_start, o_vga.frame_cnt} = w_post;

endmodule
